// File: rtl/writeback_buffer_pkg.sv
// Writeback buffer package: register-file widths and the buffered entry type.
package writeback_buffer_pkg;
`include "constants.svh"

    localparam int REG_ADDR_SIZE = `REG_ADDR_SIZE;
    localparam int REG_SIZE      = `REG_SIZE;

    // One pending register-file write.
    typedef struct packed {
        logic [REG_ADDR_SIZE-1:0] dst;
        logic [REG_SIZE-1:0]      data;
    } wb_entry_t;
endpackage

// File: rtl/writeback_buffer_if.sv
// Writeback buffer bus: load/ALU requests, register-file write port,
// forwarding lookup and occupancy status.
interface writeback_buffer_if
    import writeback_buffer_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                     MemValid;
    logic [REG_ADDR_SIZE-1:0] MemReg;
    logic [REG_SIZE-1:0]      MemData;
    logic                     MemReady;

    logic                     AluValid;
    logic [REG_ADDR_SIZE-1:0] AluReg;
    logic [REG_SIZE-1:0]      AluData;
    logic                     AluReady;

    logic                     WriteEnable;
    logic [REG_ADDR_SIZE-1:0] WriteReg;
    logic [REG_SIZE-1:0]      WriteData;

    logic [REG_ADDR_SIZE-1:0] ReadRegA;
    logic [REG_ADDR_SIZE-1:0] ReadRegB;
    logic                     FwdHitA;
    logic                     FwdHitB;
    logic [REG_SIZE-1:0]      FwdDataA;
    logic [REG_SIZE-1:0]      FwdDataB;

    logic [CW-1:0]            Count;
    logic                     Full;
    logic                     Empty;

    // Pipeline side: issues requests and read addresses.
    modport master (
        output MemValid, MemReg, MemData, AluValid, AluReg, AluData, ReadRegA, ReadRegB,
        input  MemReady, AluReady, WriteEnable, WriteReg, WriteData,
        input  FwdHitA, FwdHitB, FwdDataA, FwdDataB, Count, Full, Empty
    );

    // Buffer side.
    modport slave (
        input  MemValid, MemReg, MemData, AluValid, AluReg, AluData, ReadRegA, ReadRegB,
        output MemReady, AluReady, WriteEnable, WriteReg, WriteData,
        output FwdHitA, FwdHitB, FwdDataA, FwdDataB, Count, Full, Empty
    );
endinterface

// File: rtl/constants.svh
// Shared register-file geometry for the core.
`ifndef WB_CONSTANTS_SVH
`define WB_CONSTANTS_SVH

`define REG_ADDR_SIZE 5
`define REG_SIZE      32
`define NUM_REGS      32

`endif

// File: rtl/writeback_buffer_fwd_lookup.sv
// Forwarding lookup for one read address. Entries arrive ordered oldest
// (index 0) to youngest; the youngest valid match wins.
module wb_fwd_lookup
    import writeback_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t [DEPTH-1:0]     i_ent,
    input  logic [DEPTH-1:0]          i_vld,
    input  logic [REG_ADDR_SIZE-1:0]  i_addr,
    output logic                      o_hit,
    output logic [REG_SIZE-1:0]       o_data
);
    // Scan oldest to youngest so later matches overwrite earlier ones.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (i_vld[k] && (i_ent[k].dst == i_addr)) begin
                o_hit  = 1'b1;
                o_data = i_ent[k].data;
            end
        end
    end
endmodule

// File: rtl/writeback_buffer.sv
// Writeback buffer: merges load and ALU writebacks into a circular FIFO that
// drains into the register file one entry per cycle. Load requests have
// fixed priority over ALU requests.
// Optional forwarding lookup is built when WB_FORWARD_EN is defined.
module writeback_buffer
    import writeback_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    writeback_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    wb_entry_t     r_mem [DEPTH];

    logic      w_full;
    logic      w_empty;
    logic      w_enq;
    logic      w_deq;
    wb_entry_t w_enq_entry;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Readiness depends only on registered occupancy, never on the same-cycle
    // dequeue, so a full buffer does not accept even while draining.
    assign bus.MemReady = !w_full && !rst;
    assign bus.AluReady = !w_full && !bus.MemValid && !rst;

    assign w_enq = (bus.MemValid && bus.MemReady) || (bus.AluValid && bus.AluReady);

    // Write is suppressed while reset is high so entries being discarded
    // never reach the register file.
    assign w_deq = !w_empty && !rst;

    // Select the accepted request; load wins whenever it is valid.
    always_comb begin
        w_enq_entry = '{dst: bus.AluReg, data: bus.AluData};
        if (bus.MemValid) begin
            w_enq_entry = '{dst: bus.MemReg, data: bus.MemData};
        end
    end

    assign bus.WriteEnable = w_deq;
    assign bus.WriteReg    = r_mem[r_head].dst;
    assign bus.WriteData   = r_mem[r_head].data;
    assign bus.Count       = r_count;
    assign bus.Full        = w_full;
    assign bus.Empty       = w_empty;

    // Pointer and occupancy state; pointers wrap naturally since DEPTH is 2^AW.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_tail <= r_tail + AW'(1);
            if (w_deq) r_head <= r_head + AW'(1);
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
        end
    end

    // Entry storage, no reset: contents are meaningless outside head..tail.
    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_tail] <= w_enq_entry;
    end

`ifdef WB_FORWARD_EN
    wb_entry_t [DEPTH-1:0] w_age_ent;
    logic [DEPTH-1:0]      w_age_vld;

    // Present entries in age order starting at the head; only the first
    // Count of them are live.
    for (genvar k = 0; k < DEPTH; k++) begin : g_age
        assign w_age_ent[k] = r_mem[r_head + AW'(k)];
        assign w_age_vld[k] = (CW'(k) < r_count);
    end

    wb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd_a (
        .i_ent  (w_age_ent),
        .i_vld  (w_age_vld),
        .i_addr (bus.ReadRegA),
        .o_hit  (bus.FwdHitA),
        .o_data (bus.FwdDataA)
    );

    wb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd_b (
        .i_ent  (w_age_ent),
        .i_vld  (w_age_vld),
        .i_addr (bus.ReadRegB),
        .o_hit  (bus.FwdHitB),
        .o_data (bus.FwdDataB)
    );
`else
    logic w_unused_rd;

    // Forwarding disabled: ports stay, results tied off.
    assign w_unused_rd  = ^{bus.ReadRegA, bus.ReadRegB};
    assign bus.FwdHitA  = 1'b0;
    assign bus.FwdHitB  = 1'b0;
    assign bus.FwdDataA = '0;
    assign bus.FwdDataB = '0;
`endif
endmodule

// File: doc/writeback_buffer.md
WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, buffer entry count (power of two, >= 2).
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock of the block.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port MemValid  input  1  load-unit writeback request.
REQ-005 SHALL have ports MemReg  input  REG_ADDR_SIZE and MemData  input  REG_SIZE, the load destination and data.
REQ-006 SHALL have port MemReady  output  1  load request accepted this cycle.
REQ-007 SHALL have port AluValid  input  1  ALU writeback request.
REQ-008 SHALL have ports AluReg  input  REG_ADDR_SIZE and AluData  input  REG_SIZE, the ALU destination and data.
REQ-009 SHALL have port AluReady  output  1  ALU request accepted this cycle.
REQ-010 SHALL have ports WriteEnable  output  1, WriteReg  output  REG_ADDR_SIZE and WriteData  output  REG_SIZE, driving the register file write port.
REQ-011 SHALL have ports ReadRegA and ReadRegB, each input REG_ADDR_SIZE, the register file read addresses used for forwarding lookup.
REQ-012 SHALL have ports FwdHitA/FwdHitB  output  1 and FwdDataA/FwdDataB  output  REG_SIZE, the forwarding result per read address.
REQ-013 SHALL have ports Count  output  $clog2(DEPTH+1), Full  output  1 and Empty  output  1, the occupancy status.

Function
REQ-014 SHALL store entries {reg, data} in a circular FIFO with head and tail pointers that wrap modulo DEPTH.
REQ-015 SHALL give Mem fixed priority: MemReady = !Full && !rst; AluReady = !Full && !MemValid && !rst.
REQ-016 SHALL enqueue at most one entry per cycle, on (MemValid && MemReady) or (AluValid && AluReady).
REQ-017 SHALL drive WriteEnable = !Empty combinationally, with WriteReg/WriteData taken from the head entry.
REQ-018 SHALL dequeue the head on every edge where WriteEnable = 1; the register file never stalls.
REQ-019 SHALL have a minimum latency of one cycle: an entry accepted at edge N is presented with WriteEnable in cycle N+1 and written at edge N+1.
REQ-020 SHALL, on simultaneous enqueue and dequeue, leave Count unchanged and advance both pointers.
REQ-021 SHALL NOT pass through on Full: when Full, both Ready outputs are 0, even though a dequeue occurs that cycle.
REQ-022 SHALL keep Count in the range 0..DEPTH, with Full = (Count == DEPTH) and Empty = (Count == 0).
REQ-023 SHALL buffer writes to register 0 like any other write; no special-casing.
REQ-024 SHALL, for forwarding, compare each read address against all valid entries including the head; FwdHit = 1 on any match, and FwdData = data of the youngest matching entry.
REQ-025 SHALL give forwarding lookup no visibility of requests being enqueued in the same cycle; FwdHit = 0 when the buffer is Empty.

Reset
REQ-026 SHALL, on a rst-high edge, clear head, tail and Count, which yields Empty = 1, Full = 0, WriteEnable = 0 and FwdHitA/B = 0.
REQ-027 SHALL hold MemReady and AluReady at 0 while rst = 1; requests presented during reset are not accepted.
REQ-028 SHALL discard pending entries when reset is asserted mid-operation; no register file write occurs for them.
REQ-029 SHALL NOT reset entry storage; its contents are don't-care while invalid.

Configuration
REQ-030 SHALL use macro WB_FORWARD_EN: when defined, forwarding per REQ-024/025 is present.
REQ-031 SHALL, when WB_FORWARD_EN is not defined, tie FwdHitA/B to 0 and FwdDataA/B to 0, omit the compare logic, and leave the ports present.

Structure
REQ-032 SHALL take REG_ADDR_SIZE, REG_SIZE and NUM_REGS from rtl/constants.svh.
REQ-033 SHALL have the wb_entry_t struct {reg, data} added to the shared constants package.
REQ-034 SHALL implement forwarding lookup as a sub-module wb_fwd_lookup, instantiated twice (ports A and B).

Verification
REQ-035 SHALL cover single ALU write: AluValid, AluReg = 5, AluData = 0xDEADBEEF for 1 cycle -> next cycle WriteEnable = 1, WriteReg = 5, WriteData = 0xDEADBEEF; Empty afterwards.
REQ-036 SHALL cover the priority clash: MemValid (reg 3, 0x11) and AluValid (reg 4, 0x22) together -> MemReady = 1, AluReady = 0; reg 3 written before reg 4.
REQ-037 SHALL cover fill to full: DEPTH = 4, 4 back-to-back ALU writes with WriteEnable draining -> Count never exceeds 4; when Full, AluReady = 0 and MemReady = 0; all 4 written in order.
REQ-038 SHALL cover youngest-match forwarding: buffer reg 7 = 0x1 then reg 7 = 0x2, ReadRegA = 7 -> FwdHitA = 1, FwdDataA = 0x2; ReadRegB = 8 -> FwdHitB = 0.
REQ-039 SHALL cover reset mid-operation: 3 entries pending, rst for 1 cycle -> Count = 0, WriteEnable = 0, and no further writes of those entries.
REQ-040 SHALL cover the build without WB_FORWARD_EN: repeat REQ-038 -> FwdHitA = FwdHitB = 0, FwdData = 0.
